// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with programmable wait states
// One request at a time: accept, count down wait states, access word memory, hold response.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  busy
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          accept;
    logic          access;
    logic          acc_err;
    logic [AW-1:0] index;

    assign accept  = req_valid && req_ready;
    assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign acc_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);
    assign index   = addr_q[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst_n && (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        busy       = (state_q != S_IDLE);
        resp_rdata = rdata_q;
        resp_error = error_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (accept) begin
            cnt_d   = 4'(WAIT_CYCLES);
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (access) begin
            error_d = acc_err;
            rdata_d = (!write_q && !acc_err) ? mem[index] : '0;
        end
        // Response registers return to zero once the initiator takes them.
        if ((state_q == S_RESP) && resp_ready) begin
            rdata_d = '0;
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Storage survives reset; an aborted store never reaches the access edge.
    always_ff @(posedge clk) begin
        if (access && write_q && !acc_err) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_write, resp_ready;
    logic [1:0]  req_ready, resp_valid, resp_error, busy;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] resp_rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_error(resp_error[0]), .busy(busy[0])
    );

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_error(resp_error[1]), .busy(busy[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble(input int d, input bit hold);
        if (hold) begin
            req_write[d] = 1'($urandom);
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int bp, input bit hold);
        int          k;
        int          idx;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = 1'b0;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[d]) begin
            check("req_ready_timeout", 0, 1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
        idx     = int'(addr[9:2]);
        chk_rd  = wr || exp_err || known[d][idx];
        if (!exp_err && wr) begin
            mdl[d][idx]   = wdata;
            known[d][idx] = 1'b1;
        end
        exp_rd = (wr || exp_err) ? 32'd0 : mdl[d][idx];
        @(negedge clk);
        if (hold) scramble(d, 1'b1);
        else req_valid[d] = 1'b0;
        k = 0;
        while (!resp_valid[d] && k < 50) begin
            check("wait_busy_noready", {busy[d], req_ready[d]}, 2'b10);
            @(negedge clk);
            k++;
            scramble(d, hold);
        end
        check("latency", k, wait_of(d) + 1);
        check("resp_error", resp_error[d], exp_err);
        if (chk_rd) check("resp_rdata", resp_rdata[d], exp_rd);
        check("resp_noready", req_ready[d], 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            scramble(d, hold);
            check("bp_valid_ready", {resp_valid[d], req_ready[d], resp_error[d]}, {2'b10, exp_err});
            if (chk_rd) check("bp_rdata", resp_rdata[d], exp_rd);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check("idle_after_resp", {resp_valid[d], busy[d], req_ready[d]}, 3'b001);
        req_valid[d] = 1'b0;
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            check("rst_ctrl", {req_ready[d], resp_valid[d], busy[d], resp_error[d]}, 4'b0000);
            check("rst_rdata", resp_rdata[d], 0);
        end
    endtask

    // Store on DUT0 interrupted by reset either in WAIT (late=0) or in RESP (late=1).
    task automatic txn_reset(input logic [31:0] addr, input logic [31:0] wdata, input bit late);
        int k;
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_addr[0]   = addr;
        req_wdata[0]  = wdata;
        resp_ready[0] = 1'b0;
        k = 0;
        while (!req_ready[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        if (late) begin
            k = 0;
            while (!resp_valid[0] && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("late_reached_resp", resp_valid[0], 1);
            mdl[0][addr[9:2]] = wdata;
        end else begin
            check("early_in_wait", {busy[0], resp_valid[0]}, 2'b10);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy[0], resp_valid[0], req_ready[0]}, 3'b001);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          d;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            for (int j = 0; j < 256; j++) begin
                known[i][j] = 1'b0;
                mdl[i][j]   = '0;
            end
        end
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) txn(0, 1'b1, 32'(i * 4), $urandom, 0, 1'b0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        check("load_deadbeef_model", mdl[0][4], 32'hDEADBEEF);

        txn(0, 1'b0, 32'h12, 32'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h400, 32'h0, 0, 1'b0);
        txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, 0, 1'b0);
        txn(0, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b0);

        txn_reset(32'h20, 32'h12345678, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        txn_reset(32'h24, 32'hCAFEF00D, 1'b1);
        txn(0, 1'b0, 32'h24, 32'h0, 0, 1'b0);

        txn(1, 1'b1, 32'h4, 32'h0BADF00D, 0, 1'b0);
        txn(1, 1'b0, 32'h4, 32'h0, 0, 1'b0);

        txn(0, 1'b1, 32'h30, 32'h13579BDF, 1, 1'b1);
        txn(0, 1'b0, 32'h30, 32'h0, 2, 1'b1);

        for (int i = 0; i < 80; i++) begin
            d   = (i % 4 == 3) ? 1 : 0;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            else if (sel < 9) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else              a = 32'h400 + $urandom_range(0, 32'hFFFF);
            txn(d, 1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
